// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared state encoding, constants and cache geometry helpers for the fetch unit
package if_pkg;

    // Fetch controller states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_WAIT = 2'd1,
        DROP      = 2'd2
    } if_state_e;

    // A zero word is the bubble marker seen by IF/ID
    localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
    localparam logic [31:0] BUBBLE_PC    = 32'h0000_0000;
    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    // Tag bits left after dropping the byte offset and the line index
    function automatic int icache_tag_bits(input int addr_bits, input int index_bits);
        return addr_bits - 2 - index_bits;
    endfunction

    // Number of lines held by a direct-mapped cache of one word per line
    function automatic int icache_lines(input int index_bits);
        return 1 << index_bits;
    endfunction

endpackage

// File: rtl/if_icache.sv
// rtl/if_icache.sv - direct-mapped one-word-per-line instruction cache, present only when IF_ICACHE_EN is defined
`ifdef IF_ICACHE_EN
module if_icache
    import if_pkg::*;
#(
    parameter int INDEX_BITS = 7,
    parameter int ADDR_BITS  = 18
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_BITS-3:0] rd_addr_i,
    output logic                 hit_o,
    output logic [31:0]          rd_data_o,
    input  logic                 wr_en_i,
    input  logic [ADDR_BITS-3:0] wr_addr_i,
    input  logic [31:0]          wr_data_i
);
    localparam int TAG_BITS = icache_tag_bits(ADDR_BITS, INDEX_BITS);
    localparam int LINES    = icache_lines(INDEX_BITS);

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    logic [INDEX_BITS-1:0] rd_idx;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [TAG_BITS-1:0]   wr_tag;

    assign rd_idx = rd_addr_i[INDEX_BITS-1:0];
    assign rd_tag = rd_addr_i[ADDR_BITS-3:INDEX_BITS];
    assign wr_idx = wr_addr_i[INDEX_BITS-1:0];
    assign wr_tag = wr_addr_i[ADDR_BITS-3:INDEX_BITS];

    // Lookup is purely combinational so IDLE can decide hit/miss in the same cycle
    always_comb begin
        hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_data_o = data_q[rd_idx];
    end

    // Valid bits are the only state that reset must clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data are meaningless while the line is invalid, so they carry no reset
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data_i;
        end
    end

endmodule
`endif

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, miss handling and IF/ID outputs; IF_ICACHE_EN adds the instruction cache
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int ICACHE_INDEX_BITS = 7,
    parameter int ADDR_BITS         = 18
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [5:0]  stall_in,
    input  logic        branch_or_not,
    input  logic [31:0] branch_target,
    output logic        mc_req_out,
    output logic [31:0] mc_addr_out,
    input  logic        mc_done_in,
    input  logic [31:0] mc_data_in,
    output logic [31:0] output_pc,
    output logic [31:0] output_instru,
    output logic        if_stall_req_out
);
    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        mc_req_q, mc_req_d;
    logic [31:0] mc_addr_q, mc_addr_d;

    logic        lookup_hit;
    logic [31:0] lookup_data;
    logic        fill_en;

    // A returning word always lands in the cache, whether it is presented or dropped
    assign fill_en = rdy_in && (state_q != IDLE) && mc_done_in;

`ifdef IF_ICACHE_EN
    if_icache #(
        .INDEX_BITS (ICACHE_INDEX_BITS),
        .ADDR_BITS  (ADDR_BITS)
    ) u_icache (
        .clk_i     (clk_in),
        .rst_i     (rst_in),
        .rd_addr_i (pc_q[ADDR_BITS-1:2]),
        .hit_o     (lookup_hit),
        .rd_data_o (lookup_data),
        .wr_en_i   (fill_en),
        .wr_addr_i (mc_addr_q[ADDR_BITS-1:2]),
        .wr_data_i (mc_data_in)
    );

    logic unused_inputs;
    assign unused_inputs = ^stall_in[5:1];
`else
    // Without a cache every lookup misses and the returned word is forwarded directly
    assign lookup_hit  = 1'b0;
    assign lookup_data = BUBBLE_INSTR;

    logic unused_inputs;
    assign unused_inputs = ^{stall_in[5:1], fill_en, ICACHE_INDEX_BITS[0], ADDR_BITS[0]};
`endif

    // Stall IF/ID whenever no word can be produced this cycle
    assign if_stall_req_out = (state_q != IDLE) || !lookup_hit;

    assign mc_req_out    = mc_req_q;
    assign mc_addr_out   = mc_addr_q;
    assign output_pc     = out_pc_q;
    assign output_instru = out_instr_q;

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a branch during an outstanding miss turns it into a drop unless the word arrives now
    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            case (state_q)
                IDLE: begin
                    if (!branch_or_not && !stall_in[0] && !lookup_hit) begin
                        state_d = MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (mc_done_in) begin
                        state_d = IDLE;
                    end else if (branch_or_not) begin
                        state_d = DROP;
                    end
                end
                DROP: begin
                    if (mc_done_in) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output/datapath next values: branch beats everything and always leaves a bubble
    always_comb begin
        pc_d        = pc_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        mc_req_d    = mc_req_q;
        mc_addr_d   = mc_addr_q;
        if (rdy_in) begin
            if ((state_q != IDLE) && mc_done_in) begin
                mc_req_d = 1'b0;
            end
            if (branch_or_not) begin
                pc_d        = branch_target;
                out_pc_d    = BUBBLE_PC;
                out_instr_d = BUBBLE_INSTR;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!stall_in[0]) begin
                            if (lookup_hit) begin
                                out_pc_d    = pc_q;
                                out_instr_d = lookup_data;
                                pc_d        = pc_q + PC_STEP;
                            end else begin
                                mc_req_d    = 1'b1;
                                mc_addr_d   = {pc_q[31:2], 2'b00};
                                out_pc_d    = BUBBLE_PC;
                                out_instr_d = BUBBLE_INSTR;
                            end
                        end
                    end
                    MISS_WAIT: begin
`ifndef IF_ICACHE_EN
                        if (mc_done_in) begin
                            out_pc_d    = mc_addr_q;
                            out_instr_d = mc_data_in;
                            pc_d        = pc_q + PC_STEP;
                        end
`endif
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Datapath registers; async reset doubles as the memory-side abort
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc_q        <= RESET_PC;
            out_pc_q    <= BUBBLE_PC;
            out_instr_q <= BUBBLE_INSTR;
            mc_req_q    <= 1'b0;
            mc_addr_q   <= 32'h0;
        end else begin
            pc_q        <= pc_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            mc_req_q    <= mc_req_d;
            mc_addr_q   <= mc_addr_d;
        end
    end

endmodule
